pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the multi-cycle RISC-V core, sitting between the control FSM and instruction memory. It holds the fetch address and advances it by a fixed byte step once every CPI cycles, exposing the instruction phase to the control path. It also accepts jump/branch redirects with alignment checking and trap redirects with exception-PC capture. It supports stalls, configurable address width, reset vector and cycles-per-instruction.

---
 rtl/pc_sequencer_if.sv | 59 +++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle of the control-path signals exchanged between the control FSM
// (master) and the program-counter sequencer (slave).
//
// Handshake semantics: there is no ready signal. j_signal and trap are
// single-cycle valid strobes that the sequencer always accepts on the
// rising edge where they are high; jump is only meaningful while j_signal
// is high. stall is a level, sampled every cycle. All sequencer outputs
// are valid every cycle after reset.
interface pc_sequencer_if #(
  parameter int XLEN    = 32,
  parameter int PHASE_W = 3
);

  // Requests from the control path
  logic               stall;
  logic               j_signal;
  logic [XLEN-1:0]    jump;
  logic               trap;

  // Sequencer state presented back to the control path / instruction memory
  logic [XLEN-1:0]    next_pc;
  logic [XLEN-1:0]    pc_seq;
  logic [PHASE_W-1:0] phase;
  logic               instr_start;
  logic               retire;
  logic               misalign_err;
  logic [XLEN-1:0]    epc;

  // Control FSM side: issues requests, observes PC state
  modport master (
    output stall,
    output j_signal,
    output jump,
    output trap,
    input  next_pc,
    input  pc_seq,
    input  phase,
    input  instr_start,
    input  retire,
    input  misalign_err,
    input  epc
  );

  // Sequencer side: consumes requests, drives PC state
  modport slave (
    input  stall,
    input  j_signal,
    input  jump,
    input  trap,
    output next_pc,
    output pc_seq,
    output phase,
    output instr_start,
    output retire,
    output misalign_err,
    output epc
  );

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multi-cycle core.
// Holds the fetch address, advances it by STEP once every CPI cycles,
// and services trap and jump/branch redirects (with alignment checking).
// Per-cycle priority: rst > trap > j_signal (aligned) > stall > sequential.
// The interface instance must be built with PHASE_W = max(1, clog2(CPI)).
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              CPI          = 5,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam int PHASE_W = (CPI > 1) ? $clog2(CPI) : 1;

  // Low address bits that must be zero for a legal redirect target.
  localparam logic [XLEN-1:0]    ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0]    STEP_V     = XLEN'(STEP);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CPI - 1);

  // What the sequencer does this cycle; decoded once so the register
  // update below reads as a plain case on the chosen action.
  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,  // stalled: phase and PC frozen
    ACT_TICK    = 3'd1,  // mid-instruction: phase advances
    ACT_ADVANCE = 3'd2,  // last phase: PC steps, phase wraps, retire
    ACT_JUMP    = 3'd3,  // aligned redirect accepted
    ACT_TRAP    = 3'd4   // trap redirect with EPC capture
  } action_e;

  // Registered state
  logic [XLEN-1:0]    pc_q,       pc_d;
  logic [PHASE_W-1:0] phase_q,    phase_d;
  logic [XLEN-1:0]    epc_q,      epc_d;
  logic               retire_q,   retire_d;
  logic               misalign_q, misalign_d;

  // Decode
  logic               jump_aligned;
  logic               jump_rejected;
  logic               last_phase;
  action_e            action;

  // Redirect target legality: STEP is a power of two, so masking the
  // low bits is equivalent to jump mod STEP.
  always_comb begin
    jump_aligned  = ((bus.jump & ALIGN_MASK) == '0);
    // A trap swallows any concurrent jump, including its error report.
    jump_rejected = bus.j_signal && !jump_aligned && !bus.trap;
    last_phase    = (phase_q == LAST_PHASE);
  end

  // Choose this cycle's action in priority order (reset handled in the flops).
  always_comb begin
    action = ACT_HOLD;
    if (bus.trap) begin
      action = ACT_TRAP;
    end else if (bus.j_signal && jump_aligned) begin
      action = ACT_JUMP;
    end else if (bus.stall) begin
      action = ACT_HOLD;
    end else if (last_phase) begin
      action = ACT_ADVANCE;
    end else begin
      action = ACT_TICK;
    end
  end

  // Next-state computation for PC, phase, EPC and the status pulses.
  always_comb begin
    pc_d       = pc_q;
    phase_d    = phase_q;
    epc_d      = epc_q;
    retire_d   = 1'b0;
    misalign_d = jump_rejected;

    case (action)
      ACT_TRAP: begin
        epc_d   = pc_q;
        pc_d    = TRAP_VECTOR;
        phase_d = '0;
      end
      ACT_JUMP: begin
        pc_d    = bus.jump;
        phase_d = '0;
      end
      ACT_ADVANCE: begin
        // Wraps naturally modulo 2^XLEN.
        pc_d     = pc_q + STEP_V;
        phase_d  = '0;
        retire_d = 1'b1;
      end
      ACT_TICK: begin
        phase_d = phase_q + PHASE_W'(1);
      end
      default: begin
        // ACT_HOLD keeps the defaults.
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      phase_q    <= '0;
      epc_q      <= '0;
      retire_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      phase_q    <= phase_d;
      epc_q      <= epc_d;
      retire_q   <= retire_d;
      misalign_q <= misalign_d;
    end
  end

  // Output drive: registered state plus the two combinational decodes.
  always_comb begin
    bus.next_pc      = pc_q;
    bus.pc_seq       = pc_q + STEP_V;
    bus.phase        = phase_q;
    bus.instr_start  = (phase_q == '0);
    bus.retire       = retire_q;
    bus.misalign_err = misalign_q;
    bus.epc          = epc_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of per-cycle vectors for
// the CPI=5 instance, then hand-written reset-mid-instruction and CPI=1
// sequences.
module tb_pc_sequencer;

  logic clk;
  logic rst;

  int checks;
  int failures;

  pc_sequencer_if #(.XLEN(32), .PHASE_W(3)) bus0 ();
  pc_sequencer_if #(.XLEN(32), .PHASE_W(1)) bus1 ();

  pc_sequencer #(
    .XLEN(32), .CPI(5), .STEP(4),
    .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  pc_sequencer #(
    .XLEN(32), .CPI(1), .STEP(4),
    .RESET_VECTOR(32'h0000_1000), .TRAP_VECTOR(32'h0000_0100)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall;
    logic        j;
    logic [31:0] jump;
    logic        trap;
    logic [31:0] e_pc;
    logic [2:0]  e_phase;
    logic        e_retire;
    logic        e_mis;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic st, input logic j, input logic [31:0] jmp,
                         input logic tr, input logic [31:0] pc, input logic [2:0] ph,
                         input logic ret, input logic mis, input logic [31:0] epc);
    vec_t v;
    v.stall = st; v.j = j; v.jump = jmp; v.trap = tr;
    v.e_pc = pc; v.e_phase = ph; v.e_retire = ret; v.e_mis = mis; v.e_epc = epc;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic st, input logic j, input logic [31:0] jmp, input logic tr);
    bus0.stall = st; bus0.j_signal = j; bus0.jump = jmp; bus0.trap = tr;
  endtask

  task automatic drive1(input logic st, input logic j, input logic [31:0] jmp, input logic tr);
    bus1.stall = st; bus1.j_signal = j; bus1.jump = jmp; bus1.trap = tr;
  endtask

  // One clock edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_dut0(input string tag, input logic [31:0] pc, input logic [2:0] ph,
                            input logic ret, input logic mis, input logic [31:0] epc);
    chk({tag, " next_pc"},      bus0.next_pc, pc);
    chk({tag, " pc_seq"},       bus0.pc_seq, pc + 32'd4);
    chk({tag, " phase"},        32'(bus0.phase), 32'(ph));
    chk({tag, " instr_start"},  32'(bus0.instr_start), 32'(ph == 3'd0));
    chk({tag, " retire"},       32'(bus0.retire), 32'(ret));
    chk({tag, " misalign_err"}, 32'(bus0.misalign_err), 32'(mis));
    chk({tag, " epc"},          bus0.epc, epc);
  endtask

  task automatic check_dut1(input string tag, input logic [31:0] pc, input logic ret,
                            input logic mis);
    chk({tag, " cpi1 next_pc"},      bus1.next_pc, pc);
    chk({tag, " cpi1 phase"},        32'(bus1.phase), 32'd0);
    chk({tag, " cpi1 retire"},       32'(bus1.retire), 32'(ret));
    chk({tag, " cpi1 misalign_err"}, 32'(bus1.misalign_err), 32'(mis));
  endtask

  // ---------------- test body ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive0(1'b0, 1'b0, 32'h0, 1'b0);
    drive1(1'b0, 1'b0, 32'h0, 1'b0);

    // Free run from reset: PC 0,4,8 at cycles 0,5,10; retire at 5 and 10.
    for (int k = 1; k <= 12; k++)
      add_vec(0, 0, 32'h0, 0, 32'(4 * (k / 5)), 3'(k % 5), (k % 5) == 0, 0, 32'h0);
    // Stall 3 cycles at phase 2 of PC 0x8.
    add_vec(1, 0, 32'h0, 0, 32'h8, 3'd2, 0, 0, 32'h0);
    add_vec(1, 0, 32'h0, 0, 32'h8, 3'd2, 0, 0, 32'h0);
    add_vec(1, 0, 32'h0, 0, 32'h8, 3'd2, 0, 0, 32'h0);
    add_vec(0, 0, 32'h0, 0, 32'h8, 3'd3, 0, 0, 32'h0);
    add_vec(0, 0, 32'h0, 0, 32'h8, 3'd4, 0, 0, 32'h0);
    add_vec(0, 0, 32'h0, 0, 32'hC, 3'd0, 1, 0, 32'h0);
    add_vec(0, 0, 32'h0, 0, 32'hC, 3'd1, 0, 0, 32'h0);
    add_vec(0, 0, 32'h0, 0, 32'hC, 3'd2, 0, 0, 32'h0);
    add_vec(0, 0, 32'h0, 0, 32'hC, 3'd3, 0, 0, 32'h0);
    // Aligned jump at phase 3 overriding stall.
    add_vec(1, 1, 32'h40, 0, 32'h40, 3'd0, 0, 0, 32'h0);
    // Misaligned jump: discarded, sequencing continues, error pulse.
    add_vec(0, 1, 32'h42, 0, 32'h40, 3'd1, 0, 1, 32'h0);
    add_vec(0, 0, 32'h0,  0, 32'h40, 3'd2, 0, 0, 32'h0);
    // Misaligned jump under stall: phase holds, error pulse.
    add_vec(1, 1, 32'h43, 0, 32'h40, 3'd2, 0, 1, 32'h0);
    add_vec(0, 0, 32'h0,  0, 32'h40, 3'd3, 0, 0, 32'h0);
    add_vec(0, 0, 32'h0,  0, 32'h40, 3'd4, 0, 0, 32'h0);
    add_vec(0, 0, 32'h0,  0, 32'h44, 3'd0, 1, 0, 32'h0);
    // Move to 0x1C, then trap together with jump 0x80.
    add_vec(0, 1, 32'h1C, 0, 32'h1C,  3'd0, 0, 0, 32'h0);
    add_vec(0, 1, 32'h80, 1, 32'h100, 3'd0, 0, 0, 32'h1C);
    // Trap with a misaligned jump: no error pulse.
    add_vec(0, 1, 32'h81, 1, 32'h100, 3'd0, 0, 0, 32'h100);
    add_vec(0, 0, 32'h0,  0, 32'h100, 3'd1, 0, 0, 32'h100);
    // PC wrap from 0xFFFF_FFFC.
    add_vec(0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 3'd0, 0, 0, 32'h100);
    add_vec(0, 0, 32'h0, 0, 32'hFFFF_FFFC, 3'd1, 0, 0, 32'h100);
    add_vec(0, 0, 32'h0, 0, 32'hFFFF_FFFC, 3'd2, 0, 0, 32'h100);
    add_vec(0, 0, 32'h0, 0, 32'hFFFF_FFFC, 3'd3, 0, 0, 32'h100);
    add_vec(0, 0, 32'h0, 0, 32'hFFFF_FFFC, 3'd4, 0, 0, 32'h100);
    add_vec(0, 0, 32'h0, 0, 32'h0,         3'd0, 1, 0, 32'h100);
    // Trap mid-instruction while stalled captures PC 0.
    add_vec(0, 0, 32'h0, 0, 32'h0,   3'd1, 0, 0, 32'h100);
    add_vec(1, 0, 32'h0, 1, 32'h100, 3'd0, 0, 0, 32'h0);

    do_reset();
    check_dut0("reset", 32'h0, 3'd0, 0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive0(vecs[i].stall, vecs[i].j, vecs[i].jump, vecs[i].trap);
      tick();
      check_dut0($sformatf("vec%0d", i + 1), vecs[i].e_pc, vecs[i].e_phase,
                 vecs[i].e_retire, vecs[i].e_mis, vecs[i].e_epc);
    end
    drive0(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset at phase 4, which would otherwise retire on the next edge.
    for (int k = 1; k <= 4; k++) tick();
    check_dut0("pre_rst", 32'h100, 3'd4, 0, 0, 32'h0);
    rst = 1'b1;
    tick();
    check_dut0("mid_rst", 32'h0, 3'd0, 0, 0, 32'h0);
    rst = 1'b0;
    tick();
    check_dut0("post_rst", 32'h0, 3'd1, 0, 0, 32'h0);

    // CPI=1: PC advances every unstalled cycle.
    do_reset();
    check_dut1("reset", 32'h1000, 0, 0);
    tick();
    check_dut1("seq1", 32'h1004, 1, 0);
    tick();
    check_dut1("seq2", 32'h1008, 1, 0);
    drive1(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check_dut1("stall", 32'h1008, 0, 0);
    drive1(1'b0, 1'b1, 32'h2000, 1'b0);
    tick();
    check_dut1("jump", 32'h2000, 0, 0);
    drive1(1'b0, 1'b1, 32'h2002, 1'b0);
    tick();
    check_dut1("misalign", 32'h2004, 1, 1);
    drive1(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check_dut1("seq3", 32'h2008, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
